// File: rtl/sha512_procb_ctrl.sv
// Chunk sequencer for the SHA-512 realign/pad stage: emits data, 0x80-pad, zero-pad
// and length commands while tracking the byte position inside the 128-byte block.
`ifndef PROCB_TOTAL_MSB
`define PROCB_TOTAL_MSB 31
`endif

module sha512_procb_ctrl #(
    parameter int A_MSB     = 8,
    parameter int CNT_MSB   = 7,
    parameter int TOTAL_MSB = `PROCB_TOTAL_MSB
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 start,
    input  logic [A_MSB:0]       addr,
    input  logic [CNT_MSB:0]     count,
    input  logic                 finish,
    input  logic [TOTAL_MSB:0]   total_bytes,
    input  logic                 stall,
    output logic                 mem_rd_en,
    output logic [A_MSB-3:0]     mem_raddr,
    input  logic [63:0]          mem_dout,
    output logic                 rl_wr_en,
    output logic [3:0]           rl_len,
    output logic [2:0]           rl_off,
    output logic [63:0]          rl_din,
    output logic                 rl_add0x80pad,
    output logic                 rl_add0pad,
    output logic                 rl_add_total,
    output logic [TOTAL_MSB:0]   rl_total_bytes,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);
    localparam int WA_W = A_MSB - 2;
    localparam int CPAD = CNT_MSB - 3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DATA  = 3'd1,
        PAD80 = 3'd2,
        PAD0  = 3'd3,
        TOTAL = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [6:0]         pos_q, pos_d;
    logic               wrap_q, wrap_d;
    logic [WA_W-1:0]    waddr_q, waddr_d;
    logic [CNT_MSB:0]   rem_q, rem_d;
    logic [2:0]         off_q, off_d;
    logic               first_q, first_d;
    logic               fin_q, fin_d;
    logic               tot_hi_q, tot_hi_d;
    logic               err_q, err_d;
    logic [TOTAL_MSB:0] total_q, total_d;
    logic               wr_en_q, wr_en_d;
    logic [3:0]         len_q, len_d;
    logic [2:0]         roff_q, roff_d;
    logic               pad80_q, pad80_d;
    logic               pad0_q, pad0_d;
    logic               addtot_q, addtot_d;
    logic               done_q, done_d;

    logic [3:0]         avail_s, data_len_s, pad_len_s;
    logic [6:0]         pos_data_s, pos_pad_s, pos_plus8_s;
    logic               last_word_s;

    // Command lengths and the byte positions they would produce
    always_comb begin
        avail_s = first_q ? (4'd8 - {1'b0, off_q}) : 4'd8;
        if (rem_q < {{CPAD{1'b0}}, avail_s}) begin
            data_len_s = rem_q[3:0];
        end else begin
            data_len_s = avail_s;
        end
        last_word_s = (rem_q == {{CPAD{1'b0}}, data_len_s});
        pad_len_s   = 4'd8 - {1'b0, pos_q[2:0]};
        pos_data_s  = pos_q + {3'b000, data_len_s};
        pos_pad_s   = pos_q + {3'b000, pad_len_s};
        pos_plus8_s = pos_q + 7'd8;
    end

    // Next-state and command decision
    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        wrap_d   = wrap_q;
        waddr_d  = waddr_q;
        rem_d    = rem_q;
        off_d    = off_q;
        first_d  = first_q;
        fin_d    = fin_q;
        tot_hi_d = tot_hi_q;
        err_d    = err_q;
        total_d  = total_q;
        wr_en_d  = 1'b0;
        len_d    = 4'd0;
        roff_d   = 3'd0;
        pad80_d  = 1'b0;
        pad0_d   = 1'b0;
        addtot_d = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (count == {(CNT_MSB+1){1'b0}}) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = DATA;
                        waddr_d = addr[A_MSB:3];
                        off_d   = addr[2:0];
                        rem_d   = count;
                        first_d = 1'b1;
                        fin_d   = finish;
                        total_d = total_bytes;
                        // An unaligned first word is only legal on an aligned stream.
                        if ((addr[2:0] != 3'd0) && (pos_q[2:0] != 3'd0)) begin
                            err_d = 1'b1;
                        end else begin
                            err_d = err_q;
                        end
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (!stall) begin
                    wr_en_d = 1'b1;
                    len_d   = data_len_s;
                    roff_d  = first_q ? off_q : 3'd0;
                    pos_d   = pos_data_s;
                    rem_d   = rem_q - {{CPAD{1'b0}}, data_len_s};
                    waddr_d = waddr_q + {{(WA_W-1){1'b0}}, 1'b1};
                    first_d = 1'b0;
                    if (!last_word_s) begin
                        state_d = DATA;
                    end else if (fin_q) begin
                        state_d = PAD80;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    state_d = DATA;
                end
            end
            PAD80: begin
                if (!stall) begin
                    pad80_d = 1'b1;
                    pad0_d  = 1'b1;
                    len_d   = pad_len_s;
                    pos_d   = pos_pad_s;
                    // Landing on 120 leaves no room for the length: an extra block follows.
                    if (pos_pad_s == 7'd120) begin
                        wrap_d = 1'b1;
                    end else begin
                        wrap_d = wrap_q;
                    end
                    state_d = PAD0;
                end else begin
                    state_d = PAD80;
                end
            end
            PAD0: begin
                if ((pos_q == 7'd120) && !wrap_q) begin
                    state_d  = TOTAL;
                    tot_hi_d = 1'b1;
                end else if (!stall) begin
                    pad0_d = 1'b1;
                    len_d  = 4'd8;
                    pos_d  = pos_plus8_s;
                    if (pos_plus8_s == 7'd0) begin
                        wrap_d = 1'b0;
                    end else begin
                        wrap_d = wrap_q;
                    end
                end else begin
                    state_d = PAD0;
                end
            end
            TOTAL: begin
                if (stall) begin
                    state_d = TOTAL;
                end else if (tot_hi_q) begin
                    pad0_d   = 1'b1;
                    len_d    = 4'd8;
                    pos_d    = pos_plus8_s;
                    tot_hi_d = 1'b0;
                end else begin
                    addtot_d = 1'b1;
                    len_d    = 4'd8;
                    pos_d    = 7'd0;
                    wrap_d   = 1'b0;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer state and chunk context
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            pos_q    <= 7'd0;
            wrap_q   <= 1'b0;
            waddr_q  <= {WA_W{1'b0}};
            rem_q    <= {(CNT_MSB+1){1'b0}};
            off_q    <= 3'd0;
            first_q  <= 1'b0;
            fin_q    <= 1'b0;
            tot_hi_q <= 1'b0;
            err_q    <= 1'b0;
            total_q  <= {(TOTAL_MSB+1){1'b0}};
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            wrap_q   <= wrap_d;
            waddr_q  <= waddr_d;
            rem_q    <= rem_d;
            off_q    <= off_d;
            first_q  <= first_d;
            fin_q    <= fin_d;
            tot_hi_q <= tot_hi_d;
            err_q    <= err_d;
            total_q  <= total_d;
        end
    end

    // Registered realigner command outputs
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_en_q  <= 1'b0;
            len_q    <= 4'd0;
            roff_q   <= 3'd0;
            pad80_q  <= 1'b0;
            pad0_q   <= 1'b0;
            addtot_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            wr_en_q  <= wr_en_d;
            len_q    <= len_d;
            roff_q   <= roff_d;
            pad80_q  <= pad80_d;
            pad0_q   <= pad0_d;
            addtot_q <= addtot_d;
            done_q   <= done_d;
        end
    end

    assign mem_rd_en      = (state_q == DATA) && !stall;
    assign mem_raddr      = waddr_q;
    assign rl_din         = mem_dout;
    assign rl_wr_en       = wr_en_q;
    assign rl_len         = len_q;
    assign rl_off         = roff_q;
    assign rl_add0x80pad  = pad80_q;
    assign rl_add0pad     = pad0_q;
    assign rl_add_total   = addtot_q;
    assign rl_total_bytes = total_q;
    assign busy           = (state_q != IDLE);
    assign done           = done_q;
    assign err            = err_q;

endmodule

// File: tb/tb_sha512_procb_ctrl.sv
// Directed bench for sha512_procb_ctrl: a word memory model feeds the DUT and a
// negedge monitor logs every command for comparison against hand-derived figures.
`ifndef PROCB_TOTAL_MSB
`define PROCB_TOTAL_MSB 31
`endif

module tb_sha512_procb_ctrl;
    localparam int TW = `PROCB_TOTAL_MSB + 1;

    logic          CLK, RST_N, start, finish, stall;
    logic [8:0]    addr;
    logic [7:0]    count;
    logic [TW-1:0] total_bytes, rl_total_bytes;
    logic          mem_rd_en;
    logic [5:0]    mem_raddr;
    logic [63:0]   mem_dout, rl_din;
    logic          rl_wr_en, rl_add0x80pad, rl_add0pad, rl_add_total;
    logic [3:0]    rl_len;
    logic [2:0]    rl_off;
    logic          busy, done, err;

    sha512_procb_ctrl dut (
        .CLK(CLK), .RST_N(RST_N), .start(start), .addr(addr), .count(count),
        .finish(finish), .total_bytes(total_bytes), .stall(stall),
        .mem_rd_en(mem_rd_en), .mem_raddr(mem_raddr), .mem_dout(mem_dout),
        .rl_wr_en(rl_wr_en), .rl_len(rl_len), .rl_off(rl_off), .rl_din(rl_din),
        .rl_add0x80pad(rl_add0x80pad), .rl_add0pad(rl_add0pad),
        .rl_add_total(rl_add_total), .rl_total_bytes(rl_total_bytes),
        .busy(busy), .done(done), .err(err)
    );

    typedef struct {
        int          kind;  // 0 data, 1 0x80 pad, 2 zero pad, 3 length, 9 illegal mix
        int          len;
        int          off;
        logic [63:0] din;
        int          tot;
        int          dn;
        int          cyc;
    } cmd_t;

    logic [63:0] mem [64];
    cmd_t        cmds[$];
    int          rds[$];
    int          stall_viol = 0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          cmd_base, rd_base, viol_base, start_cyc;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(posedge CLK) begin
        if (mem_rd_en) mem_dout <= mem[mem_raddr];
    end

    always @(negedge CLK) begin
        cmd_t c;
        if (mem_rd_en) begin
            rds.push_back(int'(mem_raddr));
            if (stall) stall_viol = stall_viol + 1;
        end
        if (rl_wr_en || rl_add0x80pad || rl_add0pad || rl_add_total) begin
            if (rl_wr_en && !rl_add0x80pad && !rl_add0pad && !rl_add_total) c.kind = 0;
            else if (!rl_wr_en && rl_add0x80pad && rl_add0pad && !rl_add_total) c.kind = 1;
            else if (!rl_wr_en && !rl_add0x80pad && rl_add0pad && !rl_add_total) c.kind = 2;
            else if (!rl_wr_en && !rl_add0x80pad && !rl_add0pad && rl_add_total) c.kind = 3;
            else c.kind = 9;
            c.len = int'(rl_len);
            c.off = int'(rl_off);
            c.din = rl_din;
            c.tot = int'(rl_total_bytes);
            c.dn  = int'(done);
            c.cyc = cyc;
            cmds.push_back(c);
        end
    end

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    task automatic run_chunk(input string tag, input int a, input int c, input int f,
                             input int tb_len, input int stall_from, input int poke,
                             input int exp_err);
        int got;
        cmd_base  = cmds.size();
        rd_base   = rds.size();
        viol_base = stall_viol;
        start_cyc = cyc;
        addr        = a[8:0];
        count       = c[7:0];
        finish      = f[0];
        total_bytes = tb_len[TW-1:0];
        start       = 1'b1;
        step();
        start = 1'b0;
        check_eq({tag, ":busy_after_start"}, int'(busy), 1);
        got = 0;
        for (int k = 1; k <= 400 && got == 0; k++) begin
            stall = (stall_from > 0) && (k >= stall_from) && (k < stall_from + 2);
            if (poke != 0 && k == 4) begin
                start = 1'b1;
                count = 8'd0;
            end else begin
                start = 1'b0;
            end
            step();
            if (done) got = 1;
        end
        stall = 1'b0;
        start = 1'b0;
        check_eq({tag, ":done_seen"}, got, 1);
        check_eq({tag, ":busy_at_done"}, int'(busy), 0);
        check_eq({tag, ":err"}, int'(err), exp_err);
    endtask

    task automatic check_cmds(input string tag, input int base_word, input int exp_data,
                              input int exp_first_len, input int exp_first_off,
                              input int exp_last_len, input int exp_pad80, input int exp_zero,
                              input int exp_tot, input int exp_bytes, input int exp_tb,
                              input int exp_gap);
        int n_data = 0, first_len = -1, first_off = -1, last_len = -1, later_off = 0;
        int pad80 = 0, zero = 0, tot = 0, bytes = 0, tot_seen = -1, done_n = 0;
        int done_last = 0, din_err = 0, addr_err = 0, order = 0, illegal = 0;
        int max_gap = 1, prev_cyc = 0, prev_kind = 0, lat = -1;
        for (int i = cmd_base; i < cmds.size(); i++) begin
            if (cmds[i].kind < prev_kind) order++;
            prev_kind = cmds[i].kind;
            if (cmds[i].kind != 3) bytes += cmds[i].len;
            done_n += cmds[i].dn;
            case (cmds[i].kind)
                0: begin
                    if (n_data == 0) begin
                        first_len = cmds[i].len;
                        first_off = cmds[i].off;
                    end else begin
                        if (cmds[i].off != 0) later_off++;
                        if (cmds[i].cyc - prev_cyc > max_gap) max_gap = cmds[i].cyc - prev_cyc;
                    end
                    if (cmds[i].din !== mem[(base_word + n_data) & 63]) din_err++;
                    last_len = cmds[i].len;
                    prev_cyc = cmds[i].cyc;
                    n_data++;
                end
                1: pad80 += cmds[i].len;
                2: zero++;
                3: begin
                    tot++;
                    tot_seen = cmds[i].tot;
                end
                default: illegal++;
            endcase
        end
        if (cmds.size() > cmd_base) begin
            lat       = cmds[cmd_base].cyc - start_cyc;
            done_last = cmds[cmds.size()-1].dn;
        end
        for (int i = rd_base; i < rds.size(); i++) begin
            if (rds[i] != ((base_word + i - rd_base) & 63)) addr_err++;
        end
        check_eq({tag, ":n_data"}, n_data, exp_data);
        check_eq({tag, ":n_reads"}, rds.size() - rd_base, exp_data);
        check_eq({tag, ":read_addr"}, addr_err, 0);
        check_eq({tag, ":first_len"}, first_len, exp_first_len);
        check_eq({tag, ":first_off"}, first_off, exp_first_off);
        check_eq({tag, ":later_off"}, later_off, 0);
        check_eq({tag, ":last_len"}, last_len, exp_last_len);
        check_eq({tag, ":din"}, din_err, 0);
        check_eq({tag, ":pad80_len"}, pad80, exp_pad80);
        check_eq({tag, ":zero_words"}, zero, exp_zero);
        check_eq({tag, ":len_words"}, tot, exp_tot);
        check_eq({tag, ":bytes_before_len"}, bytes, exp_bytes);
        if (exp_tot != 0) check_eq({tag, ":total_bytes"}, tot_seen, exp_tb);
        check_eq({tag, ":order"}, order, 0);
        check_eq({tag, ":illegal"}, illegal, 0);
        check_eq({tag, ":done_count"}, done_n, 1);
        check_eq({tag, ":done_on_last"}, done_last, 1);
        check_eq({tag, ":latency"}, lat, 2);
        check_eq({tag, ":max_data_gap"}, max_gap, exp_gap);
        check_eq({tag, ":rd_during_stall"}, stall_viol - viol_base, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int k = 0; k < 64; k++) begin
            mem[k] = {32'hC0DE_0000 + 32'(k), 32'h1234_5600 + 32'(k * 3)};
        end
        RST_N = 1'b0; start = 1'b0; finish = 1'b0; stall = 1'b0;
        addr = 9'd0; count = 8'd0; total_bytes = '0;
        repeat (3) step();
        check_eq("reset:busy", int'(busy), 0);
        check_eq("reset:done", int'(done), 0);
        check_eq("reset:err", int'(err), 0);
        check_eq("reset:rl_wr_en", int'(rl_wr_en), 0);
        check_eq("reset:pads", int'({rl_add0x80pad, rl_add0pad, rl_add_total}), 0);
        check_eq("reset:len_off", int'({rl_len, rl_off}), 0);
        check_eq("reset:total", int'(rl_total_bytes), 0);
        check_eq("reset:mem_rd_en", int'(mem_rd_en), 0);
        RST_N = 1'b1;
        step();

        // 100-byte final chunk; a start pulse while busy must be ignored
        run_chunk("A100", 0, 100, 1, 100, 0, 1, 0);
        check_cmds("A100", 0, 13, 8, 0, 4, 4, 3, 1, 128, 100, 1);
        // 115 bytes: 0x80 lands at 120, forcing an extra block
        run_chunk("B115", 64, 115, 1, 115, 0, 0, 0);
        check_cmds("B115", 8, 15, 8, 0, 3, 5, 17, 1, 256, 115, 1);
        run_chunk("C_unal", 5, 20, 0, 20, 0, 0, 0);
        check_cmds("C_unal", 0, 4, 3, 5, 1, 0, 0, 0, 20, 0, 1);
        // pos is 20 here; aligned addr keeps err clear
        run_chunk("D_stall", 128, 24, 0, 24, 2, 0, 0);
        check_cmds("D_stall", 16, 3, 8, 0, 8, 0, 0, 0, 24, 0, 3);

        count = 8'd0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        check_eq("E_zero:err", int'(err), 1);
        check_eq("E_zero:busy", int'(busy), 0);
        RST_N = 1'b0;
        step();
        check_eq("E_rst:err", int'(err), 0);
        RST_N = 1'b1;
        step();
        run_chunk("E_pos3", 0, 3, 0, 3, 0, 0, 0);
        check_cmds("E_pos3", 0, 1, 3, 0, 3, 0, 0, 0, 3, 0, 1);
        run_chunk("E_unal", 10, 4, 0, 4, 0, 0, 1);
        check_cmds("E_unal", 1, 1, 4, 2, 4, 0, 0, 0, 4, 0, 1);

        addr = 9'd0; count = 8'd100; finish = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        RST_N = 1'b0;
        step();
        check_eq("R_mid:busy", int'(busy), 0);
        check_eq("R_mid:rl_wr_en", int'(rl_wr_en), 0);
        check_eq("R_mid:err", int'(err), 0);
        check_eq("R_mid:mem_rd_en", int'(mem_rd_en), 0);
        RST_N = 1'b1;
        step();

        // pos 50 carried into a final chunk that ends exactly on the block boundary
        run_chunk("F1", 0, 50, 0, 50, 0, 0, 0);
        check_cmds("F1", 0, 7, 8, 0, 2, 0, 0, 0, 50, 0, 1);
        run_chunk("F2", 56, 78, 1, 128, 0, 0, 0);
        check_cmds("F2", 7, 10, 8, 0, 6, 8, 15, 1, 206, 128, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
